piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width; legal range 2..32.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 shifted first, 0 = bit WIDTH-1 shifted first.
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port load_data, input, WIDTH bits, the parallel word to serialize.
REQ-006 The block SHALL have port load_valid, input, 1 bit, the producer's word-offered flag.
REQ-007 The block SHALL have port load_ready, output, 1 bit, the block's can-accept flag.
REQ-008 The block SHALL have port sd, output, 1 bit, the serial data that feeds the downstream SIPO d input.
REQ-009 The block SHALL have port sd_valid, output, 1 bit, which is high while sd carries a frame bit.
REQ-010 The block SHALL have port frame_last, output, 1 bit, which is high with the last data bit of a frame.
REQ-011 The block SHALL have port par_slot, output, 1 bit, which is high while sd carries a parity bit.
REQ-012 The block SHALL have port busy, output, 1 bit, which is high in any state other than IDLE.

Function
REQ-013 A handshake SHALL occur on a rising clk edge with load_valid=1 and load_ready=1, and load_data SHALL be captured into an internal shift register at that edge.
REQ-014 load_data changes after the capturing edge SHALL NOT affect the frame in flight.
REQ-015 The FSM states SHALL be IDLE, SHIFT and PAR; PAR exists only in parity builds.
REQ-016 Transitions SHALL be: IDLE->SHIFT on handshake; SHIFT->SHIFT until bit count = WIDTH; then ->PAR in parity builds, else ->SHIFT on a new handshake or ->IDLE otherwise; PAR->SHIFT on handshake, else ->IDLE.
REQ-017 Latency SHALL be exactly one cycle: the first data bit appears on sd in the cycle after the handshake edge.
REQ-018 Data bits SHALL occupy WIDTH consecutive cycles with sd_valid=1, in the order set by LSB_FIRST.
REQ-019 frame_last SHALL be high for exactly one cycle, coincident with data bit WIDTH.
REQ-020 load_ready SHALL be 1 in IDLE and in the final cycle of a frame (the last data bit, or the PAR cycle in parity builds), and 0 otherwise.
REQ-021 Back-to-back frames SHALL stream with zero bubble cycles; sd_valid stays continuously high.
REQ-022 In IDLE, sd, sd_valid, frame_last and par_slot SHALL all be 0.
REQ-023 The internal bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, SHALL reset to 0 at frame start, and SHALL never wrap inside a frame.
REQ-024 Holding load_valid=1 while load_ready=0 SHALL NOT cause a capture, and the offered word SHALL be taken at the next ready cycle.
REQ-025 With LSB_FIRST=1 and WIDTH=4 feeding the downstream 4-bit SIPO, the SIPO q SHALL equal the captured word on the clk edge following frame_last.

Reset
REQ-026 Assertion of rst_n=0 SHALL, immediately and asynchronously, force state=IDLE, counter=0, shift register=0, sd=0, sd_valid=0, frame_last=0, par_slot=0 and busy=0.
REQ-027 While rst_n=0, load_ready SHALL be 0; it SHALL rise to 1 in the first cycle after rst_n deasserts.
REQ-028 Reset mid-frame SHALL discard the partial frame, and the block SHALL NOT resume it after reset.

Configuration
REQ-029 When macro PISO_TX_PARITY_EN is defined, each frame SHALL append one PAR cycle after the last data bit, with sd = even parity (XOR) of the captured word, sd_valid=1 and par_slot=1, for WIDTH+1 cycles per frame.
REQ-030 When PISO_TX_PARITY_EN is undefined, there SHALL be no PAR state, frames SHALL be WIDTH cycles long, and par_slot SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover a single frame (WIDTH=4, LSB_FIRST=1): load 4'b1011 -> sd = 1,1,0,1 in cycles 1-4, frame_last high in cycle 4, downstream SIPO q=4'b1011 one edge later.
REQ-032 The bench SHALL cover back-to-back frames: load 4'hA then 4'h5 with load_valid held -> 8 contiguous sd_valid cycles with sd = 0,1,0,1,1,0,1,0, and load_ready high only in cycles 4 and 8.
REQ-033 The bench SHALL cover a stall: load_valid=1 with 4'h3 while busy mid-frame -> no capture until the frame_last cycle, and 4'h3 is then sent with no gap.
REQ-034 The bench SHALL cover reset mid-frame: rst_n low during cycle 2 of 4'hF -> all outputs 0 immediately, and after release the block is IDLE with load_ready=1 and no further sd_valid.
REQ-035 The bench SHALL cover MSB order (LSB_FIRST=0): load 4'b1000 -> sd = 1,0,0,0.
REQ-036 The bench SHALL cover parity (PISO_TX_PARITY_EN defined): load 4'b0111 -> data cycles 1-4, then cycle 5 with sd=1 and par_slot=1, with load_ready high in cycle 5 only.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
// A WIDTH-bit word is taken on a valid/ready handshake and sent on sd one bit
// per clock, starting in the cycle after the handshake. LSB_FIRST selects the
// bit order. Back-to-back words stream with no idle cycle between frames.
// Optional feature macro: PISO_TX_PARITY_EN. When defined, each frame gets one
// extra PAR cycle that carries the even parity (XOR) of the captured word.
// state_dbg exposes the FSM state for checkers and debug.

module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sd,
    output logic             sd_valid,
    output logic             frame_last,
    output logic             par_slot,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Load handshake: a word is transferred on a rising clk edge where
    // load_valid and load_ready are both 1. The producer keeps load_data
    // stable while load_valid is high and load_ready is low. load_ready does
    // not depend on load_valid. The captured word is private to the block, so
    // later changes of load_data cannot disturb the frame in flight.

    // Wide enough to hold WIDTH; the count only ever reaches WIDTH-1 because
    // it indexes the bit currently on sd.
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             rst_done;
    logic             is_last;
    logic             frame_end;
    logic             handshake;
    logic             head_bit;

`ifdef PISO_TX_PARITY_EN
    logic             par_bit;
    logic             par_next;
`endif

    // State, bit counter and word register; all cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sreg  <= sreg_next;
        end
    end

`ifdef PISO_TX_PARITY_EN
    // Parity of the captured word, sent in the PAR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_next;
        end
    end
`endif

    // Holds load_ready low until the first clock edge after reset release,
    // so no word can be accepted while reset is being removed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Frame position decode and the ready/handshake terms.
    always_comb begin
        is_last = (state == SHIFT) && (cnt == LAST_IDX);
`ifdef PISO_TX_PARITY_EN
        frame_end = (state == PAR);
`else
        frame_end = is_last;
`endif
        load_ready = rst_done && ((state == IDLE) || frame_end);
        handshake  = load_valid && load_ready;
        head_bit   = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
    end

    // Next-state logic: capture on handshake, shift through the word, then
    // either finish, append parity, or chain straight into the next word.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sreg_next  = sreg;
`ifdef PISO_TX_PARITY_EN
        par_next   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    sreg_next  = load_data;
`ifdef PISO_TX_PARITY_EN
                    par_next   = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (!is_last) begin
                    cnt_next  = cnt + CW'(1);
                    sreg_next = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
                end else begin
`ifdef PISO_TX_PARITY_EN
                    state_next = PAR;
`else
                    if (handshake) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                        sreg_next  = load_data;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        sreg_next  = '0;
                    end
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PAR: begin
                if (handshake) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    sreg_next  = load_data;
                    par_next   = ^load_data;
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sreg_next  = '0;
                    par_next   = 1'b0;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                sreg_next  = '0;
            end
        endcase
    end

    // Serial outputs are decoded from the state so they drop to 0 the moment
    // reset forces IDLE.
    always_comb begin
        sd_valid   = (state != IDLE);
        busy       = (state != IDLE);
        frame_last = is_last;
        state_dbg  = state;
`ifdef PISO_TX_PARITY_EN
        par_slot   = (state == PAR);
        if (state == SHIFT) begin
            sd = head_bit;
        end else if (state == PAR) begin
            sd = par_bit;
        end else begin
            sd = 1'b0;
        end
`else
        par_slot   = 1'b0;
        sd         = (state == SHIFT) ? head_bit : 1'b0;
`endif
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: drives two piso_tx instances (LSB-first and MSB-first, WIDTH=4)
// with the same inputs and compares every cycle against a beat-queue model
// of the expected serial stream. A downstream 4-bit SIPO on the LSB-first
// output checks that each frame reassembles to the captured word.

module tb_piso_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] load_data;
    logic         load_valid;

    logic         rdy_l, sd_l, sdv_l, last_l, par_l, busy_l;
    logic         rdy_m, sd_m, sdv_m, last_m, par_m, busy_m;
    logic [1:0]   st_l, st_m;

    logic [W-1:0] sipo_q;

    typedef struct packed {
        logic [W-1:0] word;
        logic         sd_l;
        logic         sd_m;
        logic         last;
        logic         par;
        logic         fin;
    } beat_t;

    beat_t        exp_q[$];
    logic         rdy_ok;
    logic         m_hs;
    logic         sipo_chk;
    logic [W-1:0] sipo_exp;
    int           n_checks;
    int           n_pass;
    int           cyc;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .sd         (sd_l),
        .sd_valid   (sdv_l),
        .frame_last (last_l),
        .par_slot   (par_l),
        .busy       (busy_l),
        .state_dbg  (st_l)
    );

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .sd         (sd_m),
        .sd_valid   (sdv_m),
        .frame_last (last_m),
        .par_slot   (par_m),
        .busy       (busy_m),
        .state_dbg  (st_m)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SIPO: data bits enter at the MSB end and move toward bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sipo_q <= '0;
        end else if (sdv_l && !par_l) begin
            sipo_q <= {sd_l, sipo_q[W-1:1]};
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d: got %b, expected %b", tag, cyc, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, obs, exp);
    endtask

    // Reference model: one queue entry per serial cycle of every accepted word.
    task automatic push_frame(input logic [W-1:0] d);
        beat_t b;
        for (int i = 0; i < W; i++) begin
            b.word = d;
            b.sd_l = d[i];
            b.sd_m = d[W-1-i];
            b.last = (i == W - 1);
            b.par  = 1'b0;
`ifdef PISO_TX_PARITY_EN
            b.fin  = 1'b0;
`else
            b.fin  = (i == W - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef PISO_TX_PARITY_EN
        b.word = d;
        b.sd_l = ^d;
        b.sd_m = ^d;
        b.last = 1'b0;
        b.par  = 1'b1;
        b.fin  = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        rdy_ok   = 1'b0;
        sipo_chk = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs in force.
    task automatic model_edge();
        logic rdy;
        rdy      = (exp_q.size() == 0) ? rdy_ok : exp_q[0].fin;
        m_hs     = load_valid && rdy;
        sipo_chk = 1'b0;
        if (exp_q.size() != 0) begin
            if (exp_q[0].last) begin
                sipo_chk = 1'b1;
                sipo_exp = exp_q[0].word;
            end
            void'(exp_q.pop_front());
        end
        if (m_hs) push_frame(load_data);
        rdy_ok = 1'b1;
    endtask

    task automatic check_outputs();
        logic e_sdl, e_sdm, e_v, e_last, e_par, e_rdy;
        if (exp_q.size() == 0) begin
            e_sdl  = 1'b0;
            e_sdm  = 1'b0;
            e_v    = 1'b0;
            e_last = 1'b0;
            e_par  = 1'b0;
            e_rdy  = rdy_ok;
        end else begin
            e_sdl  = exp_q[0].sd_l;
            e_sdm  = exp_q[0].sd_m;
            e_v    = 1'b1;
            e_last = exp_q[0].last;
            e_par  = exp_q[0].par;
            e_rdy  = exp_q[0].fin;
        end
        chk("sd_lsb", sd_l, e_sdl);
        chk("sd_valid_lsb", sdv_l, e_v);
        chk("frame_last_lsb", last_l, e_last);
        chk("par_slot_lsb", par_l, e_par);
        chk("load_ready_lsb", rdy_l, e_rdy);
        chk("busy_lsb", busy_l, e_v);
        chk("sd_msb", sd_m, e_sdm);
        chk("sd_valid_msb", sdv_m, e_v);
        chk("frame_last_msb", last_m, e_last);
        chk("par_slot_msb", par_m, e_par);
        chk("load_ready_msb", rdy_m, e_rdy);
        chk("busy_msb", busy_m, e_v);
    endtask

    // One clock cycle: drive inputs, take the edge, then check 1 time unit later.
    task automatic cycle(input logic v, input logic [W-1:0] d);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
        if (sipo_chk) chk4("sipo_q", sipo_q, sipo_exp);
    endtask

    // Offer a word and hold it until the model says it was accepted.
    task automatic send(input logic [W-1:0] d);
        m_hs = 1'b0;
        for (int k = 0; k < 20 && !m_hs; k++) cycle(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, $urandom_range(0, 15));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        m_hs       = 1'b0;
        sipo_exp   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        rst_n      = 1'b1;
        model_reset();

        // Reset state, checked while reset is held and across clock edges.
        #1 rst_n = 1'b0;
        #1 check_outputs();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single frame 4'b1011, then drain to idle.
        send(4'b1011);
        idle(6);

        // Back-to-back 4'hA then 4'h5 with valid held throughout.
        send(4'hA);
        send(4'h5);
        idle(6);

        // Stall: 4'h3 offered while a frame is in flight.
        send(4'hC);
        idle(1);
        send(4'h3);
        idle(6);

        // MSB-order pattern and parity pattern.
        send(4'b1000);
        idle(6);
        send(4'b0111);
        idle(6);

        // Reset during cycle 2 of a 4'hF frame.
        send(4'hF);
        cycle(1'b0, 4'h0);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 15));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
